// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sampling master: sample width, FSM states and default address.
package adc_pkg;

  localparam int unsigned ADC_SAMPLE_W     = 12;
  localparam logic [9:0]  ADC_ADDR_DEFAULT = 10'h000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } adc_state_t;

endpackage

// File: rtl/adc_sample_fifo.sv
// First-word-fall-through sample FIFO; head reads as zero while empty.
module adc_sample_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/adc_sampler_master.sv
// Periodic single-beat Avalon-MM read master feeding a FWFT sample FIFO.
// Optional response watchdog enabled by defining ADC_SAMPLER_TIMEOUT_EN.
module adc_sampler_master
  import adc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter logic [9:0]  ADC_ADDR       = ADC_ADDR_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [15:0]                   period,
  input  logic                          clear,
  output logic [9:0]                    avm_address,
  output logic                          avm_read,
  output logic                          avm_burstcount,
  output logic [1:0]                    avm_byteenable,
  input  logic [15:0]                   avm_readdata,
  input  logic                          avm_waitrequest,
  input  logic                          avm_readdatavalid,
  output logic [ADC_SAMPLE_W-1:0]       sample_data,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          missed,
  output logic                          timeout
);

  adc_state_t  state;
  logic [15:0] tick_cnt;
  logic [15:0] tick_last;
  logic        tick;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic        ovf_evt;
  logic        miss_evt;
  logic        to_evt;
  logic        unused_hi;

  assign avm_address    = ADC_ADDR;
  assign avm_burstcount = 1'b1;
  assign avm_byteenable = '1;
  assign unused_hi      = ^avm_readdata[15:ADC_SAMPLE_W];

  // >= keeps the timer from running to wrap if period shrinks mid-count.
  assign tick_last = (period == '0) ? '0 : period - 16'd1;
  assign tick      = enable && (tick_cnt >= tick_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     tick_cnt <= '0;
    else if (!enable) tick_cnt <= '0;
    else if (tick)    tick_cnt <= '0;
    else              tick_cnt <= tick_cnt + 16'd1;
  end

`ifdef ADC_SAMPLER_TIMEOUT_EN
  localparam int unsigned     WDW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
  logic [WDW-1:0] wd_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           wd_cnt <= '0;
    else if (state != RESP) wd_cnt <= '0;
    else                    wd_cnt <= wd_cnt + 1'b1;
  end

  assign to_evt = (state == RESP) && !avm_readdatavalid && (wd_cnt == WD_LAST);
`else
  assign to_evt = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      avm_read <= 1'b0;
    end else begin
      case (state)
        IDLE: if (tick) begin
          state    <= REQ;
          avm_read <= 1'b1;
        end
        REQ: if (!avm_waitrequest) begin
          state    <= RESP;
          avm_read <= 1'b0;
        end
        RESP: if (avm_readdatavalid || to_evt) state <= IDLE;
        default: begin
          state    <= IDLE;
          avm_read <= 1'b0;
        end
      endcase
    end
  end

  assign push     = (state == RESP) && avm_readdatavalid;
  assign pop      = sample_valid && sample_ready;
  assign ovf_evt  = push && fifo_full && !pop;
  assign miss_evt = tick && (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      missed   <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (ovf_evt)       overflow <= 1'b1;
      else if (clear)    overflow <= 1'b0;
      if (miss_evt)      missed   <= 1'b1;
      else if (clear)    missed   <= 1'b0;
      if (to_evt)        timeout  <= 1'b1;
      else if (clear)    timeout  <= 1'b0;
    end
  end

  adc_sample_fifo #(
    .WIDTH (ADC_SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (avm_readdata[ADC_SAMPLE_W-1:0]),
    .pop     (pop),
    .rdata   (sample_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign sample_valid = !fifo_empty;

endmodule
